// File: rtl/simple_edge_ai_soc.sv
// simple_edge_ai_soc: flash boot-word loader, UART/GPIO/IRQ run logic, sticky trap; `define SIMPLE_EDGE_AI_SOC_UART_ECHO_EN enables RX->TX echo in RUN
module simple_edge_ai_soc #(
  parameter int BAUD_DIV = 217,
  parameter int SPI_DIV = 2,
  parameter int LCD_RST_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_uart_tx,
  input  logic        io_uart_rx,
  output logic        io_lcd_spi_clk,
  output logic        io_lcd_spi_mosi,
  output logic        io_lcd_spi_cs,
  output logic        io_lcd_spi_dc,
  output logic        io_lcd_spi_rst,
  output logic        io_lcd_backlight,
  output logic [15:0] io_gpio_out,
  input  logic [15:0] io_gpio_in,
  output logic        io_trap,
  output logic        io_compact_irq,
  output logic        io_bitnet_irq,
  output logic        io_uart_tx_irq,
  output logic        io_uart_rx_irq,
  output logic        io_flash_spi_clk,
  output logic        io_flash_spi_mosi,
  output logic        io_flash_spi_cs,
  input  logic        io_flash_spi_miso,
  output logic        io_psram_spi_clk,
  output logic        io_psram_spi_cs,
  output logic        io_psram_spi_mosi,
  input  logic        io_psram_spi_miso,
  input  logic        io_psram_spi_sio2_in,
  input  logic        io_psram_spi_sio3_in,
  output logic        io_psram_spi_sio2_out,
  output logic        io_psram_spi_sio2_oe,
  output logic        io_psram_spi_sio3_out,
  output logic        io_psram_spi_sio3_oe
);
  localparam int SW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int LW = $clog2(LCD_RST_CYCLES + 1);
  typedef enum logic [2:0] {BOOT_CMD, BOOT_DATA, CHECK, RUN, TRAP} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sdiv_q, sdiv_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [LW-1:0] lcd_cnt_q, lcd_cnt_d;
  logic [31:0] sh_q, sh_d, bw_q, bw_d;
  logic [5:0] bit_q, bit_d;
  logic [3:0] rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, last_rx_q, last_rx_d, tx_byte, banner;
  logic [8:0] tx_sh_q, tx_sh_d;
  logic [15:0] gi1_q, gis_q, gip_q, gpio_out_q, gpio_out_d;
  logic sck_q, sck_d, fcs_q, fcs_d, fmosi_q, fmosi_d;
  logic rx1_q, rxs_q, rxp_q, rx_busy_q, rx_busy_d, rx_done, rx_tick;
  logic rx_irq_q, rx_irq_d, bn_irq_q, bn_irq_d, cmp_irq_q, cmp_irq_d;
  logic tx_q, tx_d, tx_busy_q, tx_busy_d, tx_irq_q, tx_irq_d, tx_start, tx_tick;
  logic bl_q, bl_d, trap_q, trap_d, lcd_rst_q, lcd_rst_d, bad, run, unused_in;
  assign run = state_q == RUN;
  assign bad = bw_q == 32'h0 || &bw_q;
  assign banner = bad ? 8'h21 : 8'h4F;
  assign unused_in = ^{io_psram_spi_miso, io_psram_spi_sio2_in, io_psram_spi_sio3_in};
  // Flash read: one SCK edge every SPI_DIV clocks; bits advance on falling SCK, miso captured on rising SCK
  always_comb begin
    state_d = state_q;
    sdiv_d = sdiv_q;
    sck_d = sck_q;
    sh_d = sh_q;
    bit_d = bit_q;
    bw_d = bw_q;
    if (state_q == BOOT_CMD || state_q == BOOT_DATA) begin
      sdiv_d = (sdiv_q == SW'(SPI_DIV - 1)) ? '0 : sdiv_q + 1'b1;
      if (sdiv_q == SW'(SPI_DIV - 1)) begin
        sck_d = ~sck_q;
        if (!sck_q && state_q == BOOT_DATA) bw_d = {bw_q[30:0], io_flash_spi_miso};
        if (sck_q) begin
          bit_d = bit_q + 1'b1;
          sh_d = {sh_q[30:0], 1'b0};
          state_d = (bit_q == 6'd31) ? BOOT_DATA : (bit_q == 6'd63) ? CHECK : state_q;
        end
      end
    end else if (state_q == CHECK) state_d = bad ? TRAP : RUN;
    fcs_d = !(state_d == BOOT_CMD || state_d == BOOT_DATA);
    fmosi_d = !fcs_d && sh_d[31];
  end
  always_comb begin
    rx_busy_d = rx_busy_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_done = 1'b0;
    rx_tick = rx_cnt_q == ((rx_bit_q == 4'd0) ? BW'(BAUD_DIV / 2 - 1) : BW'(BAUD_DIV - 1));
    if (!rx_busy_q) begin
      rx_busy_d = rxp_q && !rxs_q;
      rx_cnt_d = '0;
      rx_bit_d = '0;
    end else if (rx_tick) begin
      rx_cnt_d = '0;
      rx_bit_d = rx_bit_q + 1'b1;
      if (rx_bit_q == 4'd0 && rxs_q) rx_busy_d = 1'b0;
      if (rx_bit_q >= 4'd1 && rx_bit_q <= 4'd8) rx_sh_d = {rxs_q, rx_sh_q[7:1]};
      if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rx_done = rxs_q;
      end
    end else rx_cnt_d = rx_cnt_q + 1'b1;
    rx_irq_d = rx_done && run;
    bn_irq_d = rx_irq_d && rx_sh_q == bw_q[31:24];
    last_rx_d = rx_irq_d ? rx_sh_q : last_rx_q;
  end
`ifdef SIMPLE_EDGE_AI_SOC_UART_ECHO_EN
  assign tx_start = state_q == CHECK || rx_irq_d;
  assign tx_byte = (state_q == CHECK) ? banner : rx_sh_q;
`else
  assign tx_start = state_q == CHECK;
  assign tx_byte = banner;
`endif
  always_comb begin
    tx_d = tx_q;
    tx_busy_d = tx_busy_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_irq_d = 1'b0;
    tx_tick = tx_cnt_q == BW'(BAUD_DIV - 1);
    if (tx_start && !tx_busy_q) begin
      tx_busy_d = 1'b1;
      tx_d = 1'b0;
      tx_sh_d = {1'b1, tx_byte};
      tx_cnt_d = '0;
      tx_bit_d = '0;
    end else if (tx_busy_q) begin
      tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
      if (tx_tick) begin
        tx_bit_d = tx_bit_q + 1'b1;
        tx_d = tx_sh_q[0];
        tx_sh_d = {1'b1, tx_sh_q[8:1]};
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_d = 1'b1;
          tx_irq_d = run;
        end
      end
    end
  end
  always_comb begin
    gpio_out_d = (state_q == TRAP) ? 16'hDEAD : run ? {last_rx_q, bw_q[7:0] ^ gis_q[7:0]} : 16'h0;
    cmp_irq_d = run && gis_q != gip_q;
    trap_d = trap_q || state_q == TRAP;
    bl_d = run;
    lcd_cnt_d = (lcd_cnt_q == LW'(LCD_RST_CYCLES)) ? lcd_cnt_q : lcd_cnt_q + 1'b1;
    lcd_rst_d = lcd_cnt_d == LW'(LCD_RST_CYCLES);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= BOOT_CMD;
      sdiv_q <= '0;
      sck_q <= 1'b0;
      fcs_q <= 1'b1;
      fmosi_q <= 1'b0;
      sh_q <= 32'h0300_0000;
      bit_q <= '0;
      bw_q <= '0;
      gi1_q <= '0;
      gis_q <= '0;
      gip_q <= '0;
      rx1_q <= 1'b1;
      rxs_q <= 1'b1;
      rxp_q <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      last_rx_q <= '0;
      rx_irq_q <= 1'b0;
      bn_irq_q <= 1'b0;
      cmp_irq_q <= 1'b0;
      tx_q <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '1;
      tx_irq_q <= 1'b0;
      gpio_out_q <= '0;
      bl_q <= 1'b0;
      trap_q <= 1'b0;
      lcd_cnt_q <= '0;
      lcd_rst_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sdiv_q <= sdiv_d;
      sck_q <= sck_d;
      fcs_q <= fcs_d;
      fmosi_q <= fmosi_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      bw_q <= bw_d;
      gi1_q <= io_gpio_in;
      gis_q <= gi1_q;
      gip_q <= gis_q;
      rx1_q <= io_uart_rx;
      rxs_q <= rx1_q;
      rxp_q <= rxs_q;
      rx_busy_q <= rx_busy_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      last_rx_q <= last_rx_d;
      rx_irq_q <= rx_irq_d;
      bn_irq_q <= bn_irq_d;
      cmp_irq_q <= cmp_irq_d;
      tx_q <= tx_d;
      tx_busy_q <= tx_busy_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_irq_q <= tx_irq_d;
      gpio_out_q <= gpio_out_d;
      bl_q <= bl_d;
      trap_q <= trap_d;
      lcd_cnt_q <= lcd_cnt_d;
      lcd_rst_q <= lcd_rst_d;
    end
  end
  assign io_uart_tx = tx_q;
  assign io_lcd_spi_clk = 1'b0;
  assign io_lcd_spi_mosi = 1'b0;
  assign io_lcd_spi_cs = 1'b1;
  assign io_lcd_spi_dc = 1'b0;
  assign io_lcd_spi_rst = lcd_rst_q;
  assign io_lcd_backlight = bl_q;
  assign io_gpio_out = gpio_out_q;
  assign io_trap = trap_q;
  assign io_compact_irq = cmp_irq_q;
  assign io_bitnet_irq = bn_irq_q;
  assign io_uart_tx_irq = tx_irq_q;
  assign io_uart_rx_irq = rx_irq_q;
  assign io_flash_spi_clk = sck_q;
  assign io_flash_spi_mosi = fmosi_q;
  assign io_flash_spi_cs = fcs_q;
  assign io_psram_spi_clk = 1'b0;
  assign io_psram_spi_cs = 1'b1;
  assign io_psram_spi_mosi = 1'b0;
  assign io_psram_spi_sio2_out = 1'b0;
  assign io_psram_spi_sio2_oe = 1'b0;
  assign io_psram_spi_sio3_out = 1'b0;
  assign io_psram_spi_sio3_oe = 1'b0;
endmodule

// File: tb/tb_simple_edge_ai_soc.sv
// tb_simple_edge_ai_soc: directed boot/trap/run/UART/GPIO checks against simple_edge_ai_soc with a behavioural flash
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end
module tb_simple_edge_ai_soc;
  localparam int BD = 8;
  logic clock = 1'b0, reset = 1'b1, rx = 1'b1, miso;
  logic [15:0] gpio_in = '0;
  logic [31:0] flash_word = '0;
  logic tx, lcd_clk, lcd_mosi, lcd_cs, lcd_dc, lcd_rst, backlight, trap, cmp_irq, bn_irq, tx_irq, rx_irq;
  logic f_clk, f_mosi, f_cs, p_clk, p_cs, p_mosi, s2o, s2oe, s3o, s3oe;
  logic [15:0] gpio_out;
  int checks = 0, failures = 0;
  int rx_n = 0, bn_n = 0, both_n = 0, cmp_n = 0, txi_n = 0, idle_bad = 0, lc = 0, fcnt = 0, rcnt = 0;
  logic [63:0] mosi_sh;
  logic [7:0] b;
  logic ok;
  int p0, p1, p2;
  always #5 clock = ~clock;
  simple_edge_ai_soc #(.BAUD_DIV(BD), .SPI_DIV(2), .LCD_RST_CYCLES(1000)) dut (
    .clock(clock), .reset(reset), .io_uart_tx(tx), .io_uart_rx(rx),
    .io_lcd_spi_clk(lcd_clk), .io_lcd_spi_mosi(lcd_mosi), .io_lcd_spi_cs(lcd_cs), .io_lcd_spi_dc(lcd_dc),
    .io_lcd_spi_rst(lcd_rst), .io_lcd_backlight(backlight), .io_gpio_out(gpio_out), .io_gpio_in(gpio_in),
    .io_trap(trap), .io_compact_irq(cmp_irq), .io_bitnet_irq(bn_irq), .io_uart_tx_irq(tx_irq),
    .io_uart_rx_irq(rx_irq), .io_flash_spi_clk(f_clk), .io_flash_spi_mosi(f_mosi), .io_flash_spi_cs(f_cs),
    .io_flash_spi_miso(miso), .io_psram_spi_clk(p_clk), .io_psram_spi_cs(p_cs), .io_psram_spi_mosi(p_mosi),
    .io_psram_spi_miso(1'b0), .io_psram_spi_sio2_in(1'b0), .io_psram_spi_sio3_in(1'b0),
    .io_psram_spi_sio2_out(s2o), .io_psram_spi_sio2_oe(s2oe), .io_psram_spi_sio3_out(s3o), .io_psram_spi_sio3_oe(s3oe)
  );
  // Flash: data bits shift out on falling SCK after the 32 command/address bits
  always @(negedge f_clk or posedge f_cs) begin
    if (f_cs) begin
      fcnt = 0;
      miso = 1'b0;
    end else begin
      fcnt++;
      if (fcnt >= 32 && fcnt < 64) miso = flash_word[63 - fcnt];
    end
  end
  always @(posedge f_clk or posedge reset) begin
    if (reset) begin
      rcnt = 0;
      mosi_sh = '0;
    end else begin
      rcnt++;
      mosi_sh = {mosi_sh[62:0], f_mosi};
    end
  end
  always @(posedge clock) begin
    if (reset) lc = 0;
    else if (!lcd_rst) lc++;
  end
  always @(negedge clock) begin
    if (rx_irq) rx_n++;
    if (bn_irq) bn_n++;
    if (rx_irq && bn_irq) both_n++;
    if (cmp_irq) cmp_n++;
    if (tx_irq) txi_n++;
    if (p_cs !== 1'b1 || p_clk !== 1'b0 || p_mosi !== 1'b0 || s2o !== 1'b0 || s2oe !== 1'b0 ||
        s3o !== 1'b0 || s3oe !== 1'b0 || lcd_cs !== 1'b1 || lcd_clk !== 1'b0) idle_bad++;
  end
  task automatic uart_get(output logic [7:0] d, output logic good);
    int n = 0;
    good = 1'b1;
    d = '0;
    while (tx && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (tx) good = 1'b0;
    else begin
      repeat (BD / 2) @(negedge clock);
      if (tx) good = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clock);
        d[i] = tx;
      end
      repeat (BD) @(negedge clock);
      if (!tx) good = 1'b0;
    end
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (BD) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BD) @(negedge clock);
    end
    rx = stop;
    repeat (BD) @(negedge clock);
    rx = 1'b1;
    repeat (2 * BD) @(negedge clock);
  endtask
  initial begin
    repeat (3) @(negedge clock);
    `CHK("rst_uart_tx", tx, 1'b1)
    `CHK("rst_flash_cs", f_cs, 1'b1)
    `CHK("rst_flash_clk_mosi", {f_clk, f_mosi}, 2'b00)
    `CHK("rst_lcd_rst", lcd_rst, 1'b0)
    `CHK("rst_backlight_trap", {backlight, trap}, 2'b00)
    `CHK("rst_gpio_out", gpio_out, 16'h0000)
    `CHK("rst_irqs", {cmp_irq, bn_irq, tx_irq, rx_irq}, 4'b0000)
    flash_word = 32'h0;
    reset = 1'b0;
    uart_get(b, ok);
    `CHK("trap_frame_ok", ok, 1'b1)
    `CHK("trap_tx_byte", b, 8'h21)
    `CHK("trap_sck_cycles", rcnt, 64)
    `CHK("trap_cmd_mosi", mosi_sh, 64'h0300_0000_0000_0000)
    `CHK("trap_flag", trap, 1'b1)
    `CHK("trap_gpio_out", gpio_out, 16'hDEAD)
    `CHK("trap_backlight", backlight, 1'b0)
    p0 = txi_n;
    repeat (2 * BD) @(negedge clock);
    `CHK("trap_no_tx_irq", txi_n - p0, 0)
    repeat (800) @(negedge clock);
    `CHK("lcd_rst_low_cycles", lc, 1000)
    `CHK("lcd_rst_high", lcd_rst, 1'b1)
    `CHK("trap_sticky", trap, 1'b1)
    flash_word = 32'hA500_0012;
    gpio_in = 16'h0003;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    `CHK("midboot_cs_low", f_cs, 1'b0)
    reset = 1'b1;
    @(negedge clock);
    `CHK("midboot_reset_trap", trap, 1'b0)
    `CHK("midboot_reset_cs", f_cs, 1'b1)
    reset = 1'b0;
    uart_get(b, ok);
    `CHK("run_frame_ok", ok, 1'b1)
    `CHK("run_banner", b, 8'h4F)
    `CHK("run_sck_cycles", rcnt, 64)
    `CHK("run_restart_cmd", mosi_sh, 64'h0300_0000_0000_0000)
    p0 = txi_n;
    repeat (2 * BD) @(negedge clock);
    `CHK("run_tx_irq", txi_n - p0, 1)
    `CHK("run_backlight", backlight, 1'b1)
    `CHK("run_trap", trap, 1'b0)
    `CHK("run_gpio_out", gpio_out, 16'h0011)
    p0 = rx_n; p1 = bn_n; p2 = both_n;
`ifdef SIMPLE_EDGE_AI_SOC_UART_ECHO_EN
    fork
      send_rx(8'hA5, 1'b1);
      uart_get(b, ok);
    join
    `CHK("echo_frame_ok", ok, 1'b1)
    `CHK("echo_byte", b, 8'hA5)
`else
    send_rx(8'hA5, 1'b1);
`endif
    `CHK("rxa5_rx_irq", rx_n - p0, 1)
    `CHK("rxa5_bitnet_irq", bn_n - p1, 1)
    `CHK("rxa5_coincident", both_n - p2, 1)
    `CHK("rxa5_gpio_hi", gpio_out[15:8], 8'hA5)
    p0 = rx_n; p1 = bn_n;
    send_rx(8'h3C, 1'b1);
    `CHK("rx3c_rx_irq", rx_n - p0, 1)
    `CHK("rx3c_no_bitnet", bn_n - p1, 0)
    `CHK("rx3c_gpio_out", gpio_out, 16'h3C11)
    repeat (12 * BD) @(negedge clock);
    p0 = cmp_n;
    gpio_in = 16'h1114;
    repeat (6) @(negedge clock);
    `CHK("gpio_compact_once", cmp_n - p0, 1)
    `CHK("gpio_out_xor", gpio_out, 16'h3C06)
    p0 = rx_n;
    send_rx(8'h77, 1'b0);
    `CHK("badstop_no_rx_irq", rx_n - p0, 0)
    `CHK("badstop_last_rx", gpio_out[15:8], 8'h3C)
    `CHK("psram_lcd_idle", idle_bad, 0)
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
